// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types, default parameters and helpers for the fifo write arbiter.
// Defines the FSM state encoding and the range2size width helper.
package fifo_wr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_DWIDTH    = 9;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_CNT_W     = 16;

    // Bits needed to hold values 0..n-1 (at least one bit).
    function automatic int range2size(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotate-priority one-hot picker: first set bit after last_owner, wrapping.
// Purely combinational so read-side schedulers can reuse it.
module fifo_wr_arbiter_rr_picker
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int LW   = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [LW-1:0]   last_owner,
    output logic [NREQ-1:0] gnt,
    output logic [LW-1:0]   idx,
    output logic            found
);

    int j;

    // Scan from last_owner+1 around the ring; first valid wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last_owner) + k) % NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = LW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter with burst locking and flush sequencing.
// Optional per-requester beat counters under FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ*DWIDTH-1:0]   req_data_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic                     flush_req_i,
    input  logic                     fifo_full_i,
    output logic                     fifo_write_o,
    output logic [DWIDTH-1:0]        fifo_data_o,
    output logic                     fifo_flush_o,
    output logic [NREQ-1:0]          grant_o
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0]    beat_cnt_o
`endif
);

    localparam int LW = $clog2(NREQ);
    localparam int BW = range2size(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || MAX_BURST > 15
        || DWIDTH < 1 || CNT_W < 1) begin : g_bad_cfg
        $error("fifo_wr_arbiter: parameter out of range");
    end

    arb_state_t      state;
    logic [NREQ-1:0] grant_q;
    logic [LW-1:0]   owner_q;
    logic [LW-1:0]   last_q;
    logic [BW-1:0]   burst_cnt;
    logic            flush_q;

    logic [NREQ-1:0] pick_gnt;
    logic [LW-1:0]   pick_idx;
    logic            pick_any;
    logic            own_valid;
    logic            accept;
    logic            burst_done;

    fifo_wr_arbiter_rr_picker #(
        .NREQ (NREQ),
        .LW   (LW)
    ) u_picker (
        .req        (req_valid_i),
        .last_owner (last_q),
        .gnt        (pick_gnt),
        .idx        (pick_idx),
        .found      (pick_any)
    );

    // Reset gates ready so nothing is accepted while rst is sampled high.
    assign req_ready_o = (state == ST_OWN && !fifo_full_i
                          && !flush_req_i && !rst) ? grant_q : '0;
    assign accept       = |(req_valid_i & req_ready_o);
    assign own_valid    = |(req_valid_i & grant_q);
    assign burst_done   = accept && (burst_cnt == BURST_LAST);
    assign fifo_write_o = accept;
    assign fifo_flush_o = flush_q;
    assign grant_o      = grant_q;

    // Owner's data slice; zero when nobody holds the grant.
    always_comb begin
        fifo_data_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                fifo_data_o = fifo_data_o
                            | req_data_i[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // Arbitration FSM: idle/own/flush with registered grant and flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            last_q    <= LW'(NREQ - 1);
            burst_cnt <= '0;
            flush_q   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (flush_req_i) begin
                        state   <= ST_FLUSH;
                        flush_q <= 1'b1;
                    end else if (pick_any) begin
                        state   <= ST_OWN;
                        grant_q <= pick_gnt;
                        owner_q <= pick_idx;
                    end
                end
                ST_OWN: begin
                    if (flush_req_i) begin
                        state     <= ST_FLUSH;
                        flush_q   <= 1'b1;
                        grant_q   <= '0;
                        burst_cnt <= '0;
                    end else if (!own_valid || burst_done) begin
                        state     <= ST_IDLE;
                        grant_q   <= '0;
                        last_q    <= owner_q;
                        burst_cnt <= '0;
                    end else if (accept) begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                end
                ST_FLUSH: begin
                    grant_q   <= '0;
                    burst_cnt <= '0;
                    if (!flush_req_i) begin
                        state   <= ST_IDLE;
                        flush_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    grant_q   <= '0;
                    burst_cnt <= '0;
                    flush_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar i = 0; i < NREQ; i++) begin : g_stats
        logic [CNT_W-1:0] cnt;

        // Saturating count of accepted beats; only rst clears it.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= '0;
            end else if (req_valid_i[i] && req_ready_o[i]
                         && cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign beat_cnt_o[i*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DWIDTH=9, MAX_BURST=4).
// Stats checks compile only with FIFO_ARB_STATS_EN.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  valid;
    logic [35:0] data;
    logic [3:0]  ready;
    logic        flush;
    logic        full;
    logic        wr;
    logic [8:0]  wdata;
    logic        fl_o;
    logic [3:0]  grant;
`ifdef FIFO_ARB_STATS_EN
    logic [63:0] cnt16;
    logic [3:0]  ready2;
    logic        wr2;
    logic [8:0]  wdata2;
    logic        fl2;
    logic [3:0]  grant2;
    logic [15:0] cnt4;
`endif

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (valid),
        .req_data_i   (data),
        .req_ready_o  (ready),
        .flush_req_i  (flush),
        .fifo_full_i  (full),
        .fifo_write_o (wr),
        .fifo_data_o  (wdata),
        .fifo_flush_o (fl_o),
        .grant_o      (grant)
`ifdef FIFO_ARB_STATS_EN
        ,
        .beat_cnt_o   (cnt16)
`endif
    );

`ifdef FIFO_ARB_STATS_EN
    fifo_wr_arbiter #(.CNT_W(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (valid),
        .req_data_i   (data),
        .req_ready_o  (ready2),
        .flush_req_i  (flush),
        .fifo_full_i  (full),
        .fifo_write_o (wr2),
        .fifo_data_o  (wdata2),
        .fifo_flush_o (fl2),
        .grant_o      (grant2),
        .beat_cnt_o   (cnt4)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = '0; flush = 1'b0; full = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; valid = '0; flush = 1'b0; full = 1'b0; data = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({grant, ready, wr, fl_o, wdata} !== 19'd0) begin
            errors++;
            $display("FAIL rst_outputs got g=%b r=%b w=%b f=%b d=%h exp all 0",
                     grant, ready, wr, fl_o, wdata);
        end
        checks++;
        if (dut.state !== 2'd0) begin
            errors++;
            $display("FAIL rst_state got %0d exp 0", dut.state);
        end
        @(negedge clk);
        rst = 1'b0; valid = 4'b0001; data = 36'h0000000AB;
        #1;
        checks++;
        if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL rst_first_idle got %b exp 0000", grant);
        end
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 4'b0001 || wr !== 1'b1 || wdata !== 9'h0AB) begin
            errors++;
            $display("FAIL rst_first_grant got g=%b w=%b d=%h exp 0001 1 0ab",
                     grant, wr, wdata);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        do_reset();
        valid = 4'b1111;
        data = {9'h1A3, 9'h1A2, 9'h1A1, 9'h1A0};
        #1;
        checks++;
        if (grant !== 4'b0000 || wr !== 1'b0) begin
            errors++;
            $display("FAIL rr_start got g=%b w=%b exp 0000 0", grant, wr);
        end
        for (int k = 0; k < 5; k++) begin
            eg = 4'b0001 << (k % 4);
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                #1;
                checks++;
                if (grant !== eg || wr !== 1'b1
                    || wdata !== 9'h1A0 + 9'(k % 4)) begin
                    errors++;
                    $display("FAIL rr_beat k=%0d b=%0d got g=%b w=%b d=%h exp %b 1 %h",
                             k, b, grant, wr, wdata, eg, 9'h1A0 + 9'(k % 4));
                end
            end
            @(negedge clk);
            #1;
            checks++;
            if (grant !== 4'b0000 || wr !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap k=%0d got g=%b w=%b exp 0000 0",
                         k, grant, wr);
            end
        end
    endtask

    task automatic test_full_stall();
        int beats;
        beats = 0;
        do_reset();
        valid = 4'b0100;
        data = 36'h0;
        data[26:18] = 9'h155;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            full = (c >= 3 && c <= 5);
            #1;
            if (wr === 1'b1) beats++;
            if (c >= 3 && c <= 5) begin
                checks++;
                if (ready !== 4'b0000 || wr !== 1'b0 || grant !== 4'b0100) begin
                    errors++;
                    $display("FAIL full_hold c=%0d got r=%b w=%b g=%b exp 0000 0 0100",
                             c, ready, wr, grant);
                end
            end else if (c <= 7) begin
                checks++;
                if (ready !== 4'b0100 || wr !== 1'b1 || wdata !== 9'h155) begin
                    errors++;
                    $display("FAIL full_beat c=%0d got r=%b w=%b d=%h exp 0100 1 155",
                             c, ready, wr, wdata);
                end
            end else begin
                checks++;
                if (grant !== 4'b0000) begin
                    errors++;
                    $display("FAIL full_release got g=%b exp 0000", grant);
                end
            end
        end
        checks++;
        if (beats !== 4) begin
            errors++;
            $display("FAIL full_total got %0d exp 4", beats);
        end
    endtask

    task automatic test_flush();
        do_reset();
        valid = 4'b0001;
        data = 36'h000000033;
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 4'b0001 || wr !== 1'b1) begin
            errors++;
            $display("FAIL fl_own got g=%b w=%b exp 0001 1", grant, wr);
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (wr !== 1'b0 || ready !== 4'b0000 || fl_o !== 1'b0) begin
            errors++;
            $display("FAIL fl_req got w=%b r=%b f=%b exp 0 0000 0", wr, ready, fl_o);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (fl_o !== 1'b1 || grant !== 4'b0000 || wr !== 1'b0) begin
            errors++;
            $display("FAIL fl_active got f=%b g=%b w=%b exp 1 0000 0", fl_o, grant, wr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (fl_o !== 1'b0 || grant !== 4'b0000 || dut.state !== 2'd0) begin
            errors++;
            $display("FAIL fl_idle got f=%b g=%b s=%0d exp 0 0000 0",
                     fl_o, grant, dut.state);
        end
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL fl_regrant got %b exp 0001", grant);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        valid = 4'b0011;
        data = {9'h0, 9'h0, 9'h0E1, 9'h0E0};
        for (int c = 1; c <= 6; c++) @(negedge clk);
        #1;
        checks++;
        if (grant !== 4'b0010 || wr !== 1'b1 || wdata !== 9'h0E1) begin
            errors++;
            $display("FAIL mid_owner1 got g=%b w=%b d=%h exp 0010 1 0e1",
                     grant, wr, wdata);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (wr !== 1'b0 || ready !== 4'b0000) begin
            errors++;
            $display("FAIL mid_rst_accept got w=%b r=%b exp 0 0000", wr, ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || dut.state !== 2'd0) begin
            errors++;
            $display("FAIL mid_rst_drop got g=%b s=%0d exp 0000 0", grant, dut.state);
        end
        @(negedge clk);
        #1;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL mid_rearb got %b exp 0001", grant);
        end
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        int seen;
        int cyc;
        seen = 0;
        cyc = 0;
        do_reset();
        valid = 4'b1000;
        data = '0;
        #1;
        while (seen < 37 && cyc < 200) begin
            @(negedge clk);
            #1;
            if (wr === 1'b1) seen++;
            cyc++;
        end
        checks++;
        if (seen !== 37) begin
            errors++;
            $display("FAIL stats_timeout got %0d beats exp 37", seen);
        end
        @(negedge clk);
        valid = '0;
        @(negedge clk);
        #1;
        checks++;
        if (cnt16[63:48] !== 16'd37 || cnt16[47:0] !== 48'd0) begin
            errors++;
            $display("FAIL stats_cnt16 got %h exp 0025_0000_0000_0000", cnt16);
        end
        checks++;
        if (cnt4[15:12] !== 4'd15) begin
            errors++;
            $display("FAIL stats_sat got %0d exp 15", cnt4[15:12]);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        valid = '0;
        data = '0;
        flush = 1'b0;
        full = 1'b0;
        test_reset();
        test_round_robin();
        test_full_stall();
        test_flush();
        test_reset_mid_burst();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
